// File: rtl/pf_ddr4_phy_pkg.sv
// Shared definitions for the DDR4 PHY receive-lane training logic:
// aligner state encoding, word width and the default training word.
package pf_ddr4_phy_pkg;

    localparam int WORD_W = 8;
    localparam logic [WORD_W-1:0] DEFAULT_PATTERN = 8'hB4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_SWEEP,
        ST_CENTER,
        ST_DONE,
        ST_FAIL
    } align_state_e;

    function automatic logic [7:0] center_tap(input logic [7:0] high);
        return high >> 1;
    endfunction

    // SLIP_COUNT is only 3 bits wide, so larger counts read back as 7.
    function automatic logic [2:0] sat_count(input int n);
        return (n > 7) ? 3'd7 : 3'(n);
    endfunction

endpackage

// File: rtl/pf_ddr4_rx_lane_align_if.sv
// Lane-side signal bundle between the receive IOD/fabric and the aligner.
interface pf_ddr4_rx_lane_align_if;
    import pf_ddr4_phy_pkg::*;

    logic              START;
    logic [WORD_W-1:0] RX_DATA;
    logic              DELAY_LINE_OUT_OF_RANGE;
    logic              RX_BIT_SLIP;
    logic              DELAY_LINE_MOVE;
    logic              DELAY_LINE_DIRECTION;
    logic              DELAY_LINE_LOAD;
    logic              BUSY;
    logic              DONE;
    logic              ERROR;
    logic [7:0]        TAP_CENTER;
    logic [2:0]        SLIP_COUNT;

    modport master (
        output START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
        input  RX_BIT_SLIP, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD,
        input  BUSY, DONE, ERROR, TAP_CENTER, SLIP_COUNT
    );

    modport slave (
        input  START, RX_DATA, DELAY_LINE_OUT_OF_RANGE,
        output RX_BIT_SLIP, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD,
        output BUSY, DONE, ERROR, TAP_CENTER, SLIP_COUNT
    );

endinterface

// File: rtl/pf_ddr4_rx_pattern_chk.sv
// Compares successive lane words against the training pattern; reports a
// verdict on the first mismatch or after MATCH_WORDS consecutive matches.
module pf_ddr4_rx_pattern_chk
    import pf_ddr4_phy_pkg::*;
#(
    parameter logic [WORD_W-1:0] PATTERN     = DEFAULT_PATTERN,
    parameter int                MATCH_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [WORD_W-1:0] data,
    output logic              done,
    output logic              pass
);

    localparam int CW = $clog2(MATCH_WORDS + 1);

    logic [CW-1:0] cnt;
    logic          hit;

    assign hit  = (data == PATTERN);
    assign pass = hit;
    assign done = en && (!hit || (cnt == CW'(MATCH_WORDS - 1)));

    // Counter restarts whenever a check is not in progress or has concluded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pf_ddr4_rx_lane_align.sv
// Receive-lane training: bit-slip until the pattern appears, sweep the delay
// line to find the top of the eye, then step back to the eye center.
module pf_ddr4_rx_lane_align
    import pf_ddr4_phy_pkg::*;
#(
    parameter logic [WORD_W-1:0] PATTERN       = DEFAULT_PATTERN,
    parameter int                MATCH_WORDS   = 4,
    parameter int                SETTLE_CYCLES = 8,
    parameter int                MAX_SLIPS     = 8,
    parameter int                MAX_TAPS      = 128
) (
    input  logic                    FAB_CLK,
    input  logic                    ARST_N,
    pf_ddr4_rx_lane_align_if.slave  lane
);

    localparam int         SCW      = $clog2(SETTLE_CYCLES + 1);
    localparam int         SLW      = $clog2(MAX_SLIPS + 1);
    localparam logic [7:0] LAST_TAP = 8'(MAX_TAPS - 1);

    align_state_e   state;
    logic [SCW-1:0] settle_cnt;
    logic [SLW-1:0] slips;
    logic [7:0]     tap;
    logic [7:0]     high;
    logic [7:0]     center;
    logic [7:0]     moves_left;
    logic           aligned;
    logic           spacing;
    logic           check_en;
    logic           chk_done;
    logic           chk_pass;
    logic           sweep_end;
    logic [7:0]     hi_next;

    assign check_en  = (state == ST_CHECK);
    assign sweep_end = (tap == LAST_TAP) || lane.DELAY_LINE_OUT_OF_RANGE;
    assign hi_next   = chk_pass ? tap : high;

    pf_ddr4_rx_pattern_chk #(
        .PATTERN     (PATTERN),
        .MATCH_WORDS (MATCH_WORDS)
    ) u_chk (
        .clk   (FAB_CLK),
        .rst_n (ARST_N),
        .en    (check_en),
        .data  (lane.RX_DATA),
        .done  (chk_done),
        .pass  (chk_pass)
    );

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state                     <= ST_IDLE;
            settle_cnt                <= '0;
            slips                     <= '0;
            tap                       <= '0;
            high                      <= '0;
            center                    <= '0;
            moves_left                <= '0;
            aligned                   <= 1'b0;
            spacing                   <= 1'b0;
            lane.RX_BIT_SLIP          <= 1'b0;
            lane.DELAY_LINE_MOVE      <= 1'b0;
            lane.DELAY_LINE_DIRECTION <= 1'b0;
            lane.DELAY_LINE_LOAD      <= 1'b0;
            lane.BUSY                 <= 1'b0;
            lane.DONE                 <= 1'b0;
            lane.ERROR                <= 1'b0;
            lane.TAP_CENTER           <= '0;
            lane.SLIP_COUNT           <= '0;
        end else begin
            lane.RX_BIT_SLIP     <= 1'b0;
            lane.DELAY_LINE_MOVE <= 1'b0;
            lane.DELAY_LINE_LOAD <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (lane.START) begin
                        state                <= ST_LOAD;
                        lane.DELAY_LINE_LOAD <= 1'b1;
                        lane.BUSY            <= 1'b1;
                        lane.DONE            <= 1'b0;
                        lane.ERROR           <= 1'b0;
                        lane.TAP_CENTER      <= '0;
                        lane.SLIP_COUNT      <= '0;
                    end
                end
                ST_LOAD: begin
                    tap     <= '0;
                    slips   <= '0;
                    high    <= '0;
                    aligned <= 1'b0;
                    state   <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SCW'(SETTLE_CYCLES - 1)) begin
                        settle_cnt <= '0;
                        state      <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (chk_done) begin
                        if (chk_pass) begin
                            aligned <= 1'b1;
                            high    <= tap;
                        end
                        if (chk_pass && !sweep_end) begin
                            state                     <= ST_SWEEP;
                            lane.DELAY_LINE_DIRECTION <= 1'b1;
                        end else if (chk_pass || aligned) begin
                            // The window top is the last passing tap; walk back half of it.
                            state                     <= ST_CENTER;
                            lane.DELAY_LINE_DIRECTION <= 1'b0;
                            center                    <= center_tap(hi_next);
                            moves_left                <= hi_next - center_tap(hi_next);
                            spacing                   <= 1'b0;
                        end else if (slips == SLW'(MAX_SLIPS)) begin
                            state      <= ST_FAIL;
                            lane.BUSY  <= 1'b0;
                            lane.ERROR <= 1'b1;
                        end else begin
                            state            <= ST_SLIP;
                            lane.RX_BIT_SLIP <= 1'b1;
                            slips            <= slips + 1'b1;
                            lane.SLIP_COUNT  <= sat_count(int'(slips) + 1);
                        end
                    end
                end
                ST_SLIP: begin
                    state <= ST_SETTLE;
                end
                ST_SWEEP: begin
                    lane.DELAY_LINE_MOVE <= 1'b1;
                    tap                  <= tap + 8'd1;
                    state                <= ST_SETTLE;
                end
                ST_CENTER: begin
                    if (moves_left == 8'd0) begin
                        state           <= ST_DONE;
                        lane.BUSY       <= 1'b0;
                        lane.DONE       <= 1'b1;
                        lane.TAP_CENTER <= center;
                    end else if (!spacing) begin
                        lane.DELAY_LINE_MOVE <= 1'b1;
                        moves_left           <= moves_left - 8'd1;
                        spacing              <= 1'b1;
                    end else begin
                        spacing <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pf_ddr4_rx_lane_align.sv
// Bench for the receive-lane aligner: a behavioural lane/delay-line model
// drives RX_DATA, and each training run is scored against expected results.
module tb_pf_ddr4_rx_lane_align;

    localparam int         MAX_SLIPS = 8;
    localparam int         MAX_TAPS  = 128;
    localparam int         NONE      = 1000;
    localparam logic [7:0] PAT       = 8'hB4;

    logic fab_clk = 1'b0;
    logic arst_n  = 1'b0;
    always #5 fab_clk = ~fab_clk;

    pf_ddr4_rx_lane_align_if bus ();

    pf_ddr4_rx_lane_align dut (
        .FAB_CLK (fab_clk),
        .ARST_N  (arst_n),
        .lane    (bus)
    );

    typedef struct {
        int ns;  int eh;  int ot;  bit zero;  bit spam;
        bit err; int slips; int center; int inc; int dec;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int cfg_ns = 0;
    int cfg_eh = 0;
    int cfg_ot = NONE;
    bit cfg_zero = 1'b0;
    bit clr = 1'b0;

    int   m_tap = 0;
    int   slip_seen = 0;
    int   load_seen = 0;
    int   inc_seen = 0;
    int   dec_seen = 0;
    int   dir_bad = 0;
    int   space_bad = 0;
    int   cyc = 0;
    int   last_move = -10;
    logic prev_dir = 1'b0;

    function automatic logic [7:0] junk();
        logic [7:0] j;
        j = 8'($urandom);
        if (j == PAT) j = ~j;
        return cfg_zero ? 8'h00 : j;
    endfunction

    // Lane and delay-line model: reacts to the pulses, then presents the next word.
    always @(negedge fab_clk) begin
        cyc++;
        if (clr) begin
            m_tap = 0; slip_seen = 0; load_seen = 0; inc_seen = 0; dec_seen = 0;
            dir_bad = 0; space_bad = 0; last_move = -10;
        end else begin
            if (bus.RX_BIT_SLIP) slip_seen++;
            if (bus.DELAY_LINE_LOAD) begin
                load_seen++;
                m_tap = 0;
            end
            if (bus.DELAY_LINE_MOVE) begin
                if (bus.DELAY_LINE_DIRECTION) begin
                    inc_seen++;
                    m_tap++;
                    if (!prev_dir) dir_bad++;
                end else begin
                    dec_seen++;
                    m_tap--;
                    if (prev_dir) dir_bad++;
                    if (cyc - last_move < 2) space_bad++;
                end
                last_move = cyc;
            end
        end
        prev_dir = bus.DELAY_LINE_DIRECTION;
        bus.DELAY_LINE_OUT_OF_RANGE = (m_tap >= cfg_ot);
        if (!cfg_zero && slip_seen >= cfg_ns && m_tap >= 0 && m_tap <= cfg_eh)
            bus.RX_DATA = PAT;
        else
            bus.RX_DATA = junk();
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t ref_model(input int ns, input int eh, input int ot);
        vec_t e;
        int   hi;
        e.ns = ns; e.eh = eh; e.ot = ot; e.zero = 1'b0; e.spam = 1'b0;
        if (ns > MAX_SLIPS) begin
            e.err = 1'b1; e.slips = MAX_SLIPS; e.center = 0; e.inc = 0; e.dec = 0;
        end else begin
            hi = eh;
            if (ot < hi) hi = ot;
            if (MAX_TAPS - 1 < hi) hi = MAX_TAPS - 1;
            e.err    = 1'b0;
            e.slips  = ns;
            e.center = hi / 2;
            e.dec    = hi - hi / 2;
            e.inc    = (eh < ot && eh < MAX_TAPS - 1) ? eh + 1 : hi;
        end
        return e;
    endfunction

    task automatic new_lane(input vec_t v);
        cfg_ns = v.ns; cfg_eh = v.eh; cfg_ot = v.ot; cfg_zero = v.zero;
        @(negedge fab_clk); #1 clr = 1'b1;
        @(negedge fab_clk); #1 clr = 1'b0;
    endtask

    task automatic run_case(input vec_t v, input string tag);
        int n;
        new_lane(v);
        bus.START = 1'b1;
        @(negedge fab_clk); #1;
        if (!v.spam) bus.START = 1'b0;
        for (n = 0; n < 20000 && !(bus.DONE || bus.ERROR); n++) begin
            @(negedge fab_clk); #1;
            if (v.spam) bus.START = bus.BUSY;
        end
        bus.START = 1'b0;
        chk({tag, ":finished"}, int'(bus.DONE || bus.ERROR), 1);
        repeat (3) @(negedge fab_clk);
        #1;
        chk({tag, ":error"}, int'(bus.ERROR), int'(v.err));
        chk({tag, ":done"}, int'(bus.DONE), int'(!v.err));
        chk({tag, ":busy"}, int'(bus.BUSY), 0);
        chk({tag, ":tap_center"}, int'(bus.TAP_CENTER), v.center);
        chk({tag, ":slip_pulses"}, slip_seen, v.slips);
        if (!v.err) chk({tag, ":slip_count"}, int'(bus.SLIP_COUNT), v.slips);
        chk({tag, ":inc_pulses"}, inc_seen, v.inc);
        chk({tag, ":dec_pulses"}, dec_seen, v.dec);
        chk({tag, ":load_pulses"}, load_seen, 1);
        chk({tag, ":direction_setup"}, dir_bad, 0);
        chk({tag, ":dec_spacing"}, space_bad, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":busy"}, int'(bus.BUSY), 0);
        chk({tag, ":done"}, int'(bus.DONE), 0);
        chk({tag, ":error"}, int'(bus.ERROR), 0);
        chk({tag, ":tap_center"}, int'(bus.TAP_CENTER), 0);
        chk({tag, ":slip_count"}, int'(bus.SLIP_COUNT), 0);
        chk({tag, ":pulses"}, int'({bus.RX_BIT_SLIP, bus.DELAY_LINE_MOVE, bus.DELAY_LINE_LOAD}), 0);
    endtask

    initial begin
        vec_t vt[6];
        vec_t v;
        int   n;
        int   moves_before;

        vt[0] = '{0, 40,   NONE, 1'b0, 1'b0, 1'b0, 0, 20, 41,  20};
        vt[1] = '{3, 10,   NONE, 1'b0, 1'b0, 1'b0, 3, 5,  11,  5};
        vt[2] = '{0, 40,   NONE, 1'b1, 1'b0, 1'b1, 8, 0,  0,   0};
        vt[3] = '{0, NONE, 127,  1'b0, 1'b0, 1'b0, 0, 63, 127, 64};
        vt[4] = '{1, NONE, 100,  1'b0, 1'b0, 1'b0, 1, 50, 100, 50};
        vt[5] = '{2, 25,   NONE, 1'b0, 1'b1, 1'b0, 2, 12, 26,  13};

        bus.START = 1'b0;
        repeat (3) @(negedge fab_clk);
        #1;
        chk_all_zero("reset");
        arst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_case(vt[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            int ns;
            int eh;
            int ot;
            ns = $urandom_range(0, 9);
            if (ns >= MAX_SLIPS) ns = MAX_SLIPS + 4;
            eh = $urandom_range(0, 50);
            ot = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 50) : NONE;
            v  = ref_model(ns, eh, ot);
            run_case(v, $sformatf("rand%0d", i));
        end

        // Abort during the sweep: reset must clear everything at once.
        new_lane(vt[0]);
        bus.START = 1'b1;
        @(negedge fab_clk); #1;
        bus.START = 1'b0;
        for (n = 0; n < 5000 && inc_seen < 15; n++) begin
            @(negedge fab_clk); #1;
        end
        chk("abort:reached_tap15", inc_seen, 15);
        chk("abort:busy_before", int'(bus.BUSY), 1);
        moves_before = inc_seen + dec_seen;
        #2 arst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        repeat (4) @(negedge fab_clk);
        #1;
        chk("abort:no_moves", inc_seen + dec_seen, moves_before);
        chk("abort:no_loads", load_seen, 1);
        arst_n = 1'b1;
        repeat (3) @(negedge fab_clk);
        #1;
        chk("abort:stays_idle", int'(bus.BUSY), 0);
        run_case(vt[0], "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
